// File: rtl/rally_judge.sv
// Rally referee: watches the ball on both paddle rows, pulses hit/miss, keeps the
// match score and holds game_over through the restart pause and after the match ends.
module rally_judge #(
  parameter int VRES          = 720,
  parameter int PADDLE_H      = 20,
  parameter int RESTART_PAUSE = 128,
  parameter int SCORE_W       = 4,
  parameter int WIN_SCORE     = 9
) (
  input  logic                      pixel_clk,
  input  logic                      rst,
  input  logic                      fsync,
  input  logic signed [11:0]        vpos,
  input  logic                      active_obj,
  input  logic                      active_paddle_p1,
  input  logic                      active_paddle_p2,
  output logic                      hit_p1,
  output logic                      hit_p2,
  output logic                      miss_p1,
  output logic                      miss_p2,
  output logic                      game_over,
  output logic                      round_restart,
  output logic [SCORE_W-1:0]        score_p1,
  output logic [SCORE_W-1:0]        score_p2,
  output logic                      match_over,
  output logic                      winner
);

  localparam logic signed [11:0] P1_ROW    = 12'(VRES - PADDLE_H);
  localparam logic signed [11:0] P2_ROW    = 12'(PADDLE_H);
  localparam logic [7:0]         PAUSE_END = 8'(RESTART_PAUSE);
  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    WAIT_FRAME,
    SCAN,
    PASSING,
    PAUSE,
    MATCH_END
  } state_t;

  state_t             state, state_n;
  logic [7:0]         pause, pause_n;
  logic               loser, loser_n;   // 0 = P1 missed, 1 = P2 missed
  logic               hit_p1_n, hit_p2_n, miss_p1_n, miss_p2_n;
  logic               game_over_n, round_restart_n, match_over_n, winner_n;
  logic [SCORE_W-1:0] score_p1_n, score_p2_n;
  logic [SCORE_W-1:0] opp_inc;

  // The player who did not miss is the one who scores.
  assign opp_inc = (loser ? score_p1 : score_p2) + 1'b1;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_n         = state;
    pause_n         = pause;
    loser_n         = loser;
    hit_p1_n        = 1'b0;
    hit_p2_n        = 1'b0;
    miss_p1_n       = 1'b0;
    miss_p2_n       = 1'b0;
    round_restart_n = 1'b0;
    game_over_n     = game_over;
    match_over_n    = match_over;
    winner_n        = winner;
    score_p1_n      = score_p1;
    score_p2_n      = score_p2;

    unique case (state)
      WAIT_FRAME: begin
        if (fsync) state_n = SCAN;
      end
      SCAN: begin
        if (vpos == P1_ROW && active_obj) begin
          if (active_paddle_p1) begin
            hit_p1_n = 1'b1;
            state_n  = WAIT_FRAME;
          end else begin
            loser_n  = 1'b0;
            state_n  = PASSING;
          end
        end else if (vpos == P2_ROW && active_obj) begin
          if (active_paddle_p2) begin
            hit_p2_n = 1'b1;
            state_n  = WAIT_FRAME;
          end else begin
            loser_n  = 1'b1;
            state_n  = PASSING;
          end
        end
      end
      PASSING: begin
        // The miss is declared once the ball has fully left the paddle row.
        if (!active_obj) begin
          miss_p1_n   = ~loser;
          miss_p2_n   = loser;
          game_over_n = 1'b1;
          pause_n     = '0;
          if (loser) score_p1_n = opp_inc;
          else       score_p2_n = opp_inc;
          if (opp_inc == WIN) begin
            match_over_n = 1'b1;
            winner_n     = ~loser;
            state_n      = MATCH_END;
          end else begin
            state_n      = PAUSE;
          end
        end
      end
      PAUSE: begin
        if (fsync) begin
          if (pause == PAUSE_END) begin
            game_over_n     = 1'b0;
            round_restart_n = 1'b1;
            pause_n         = '0;
            state_n         = WAIT_FRAME;
          end else begin
            pause_n = pause + 8'd1;
          end
        end
      end
      MATCH_END: begin
        game_over_n  = 1'b1;
        match_over_n = 1'b1;
      end
      default: state_n = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state         <= WAIT_FRAME;
      pause         <= '0;
      loser         <= 1'b0;
      hit_p1        <= 1'b0;
      hit_p2        <= 1'b0;
      miss_p1       <= 1'b0;
      miss_p2       <= 1'b0;
      game_over     <= 1'b0;
      round_restart <= 1'b0;
      match_over    <= 1'b0;
      winner        <= 1'b0;
      score_p1      <= '0;
      score_p2      <= '0;
    end else begin
      state         <= state_n;
      pause         <= pause_n;
      loser         <= loser_n;
      hit_p1        <= hit_p1_n;
      hit_p2        <= hit_p2_n;
      miss_p1       <= miss_p1_n;
      miss_p2       <= miss_p2_n;
      game_over     <= game_over_n;
      round_restart <= round_restart_n;
      match_over    <= match_over_n;
      winner        <= winner_n;
      score_p1      <= score_p1_n;
      score_p2      <= score_p2_n;
    end
  end

endmodule

// File: tb/tb_rally_judge.sv
// Directed bench for rally_judge: hit, miss, restart pause, match end, reset mid-pause
// and a row event coinciding with fsync.
module tb_rally_judge;

  logic               pixel_clk = 1'b0;
  logic               rst;
  logic               fsync;
  logic signed [11:0] vpos;
  logic               active_obj, active_paddle_p1, active_paddle_p2;
  logic               hit_p1, hit_p2, miss_p1, miss_p2;
  logic               game_over, round_restart, match_over, winner;
  logic [3:0]         score_p1, score_p2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 pixel_clk = ~pixel_clk;

  rally_judge dut (
    .pixel_clk        (pixel_clk),
    .rst              (rst),
    .fsync            (fsync),
    .vpos             (vpos),
    .active_obj       (active_obj),
    .active_paddle_p1 (active_paddle_p1),
    .active_paddle_p2 (active_paddle_p2),
    .hit_p1           (hit_p1),
    .hit_p2           (hit_p2),
    .miss_p1          (miss_p1),
    .miss_p2          (miss_p2),
    .game_over        (game_over),
    .round_restart    (round_restart),
    .score_p1         (score_p1),
    .score_p2         (score_p2),
    .match_over       (match_over),
    .winner           (winner)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic pulse_fsync();
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
  endtask

  task automatic fsyncs(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_fsync();
      tick();
    end
  endtask

  function automatic logic [15:0] all_out();
    return {hit_p1, hit_p2, miss_p1, miss_p2, game_over, round_restart,
            match_over, winner, score_p1, score_p2};
  endfunction

  // One P1 miss from WAIT_FRAME: fsync, ball on row 700 without paddle, ball leaves.
  task automatic miss_p1_round();
    pulse_fsync();
    vpos = 12'sd700; active_obj = 1'b1; active_paddle_p1 = 1'b0;
    tick();
    active_obj = 1'b0; vpos = 12'sd0;
    tick();
  endtask

  logic [15:0] acc;

  initial begin
    rst = 1'b1; fsync = 1'b0; vpos = '0;
    active_obj = 1'b0; active_paddle_p1 = 1'b0; active_paddle_p2 = 1'b0;
    tick();
    tick();
    check("reset_outputs", 32'(all_out()), 32'h0);
    rst = 1'b0;

    // Ball on the row while still waiting for a frame is ignored.
    vpos = 12'sd700; active_obj = 1'b1; active_paddle_p1 = 1'b1;
    tick();
    check("wait_ignores_row", 32'(all_out()), 32'h0);
    active_obj = 1'b0; active_paddle_p1 = 1'b0;

    // T1 hit
    pulse_fsync();
    vpos = 12'sd700; active_obj = 1'b1; active_paddle_p1 = 1'b1;
    tick();
    check("t1_hit_p1", 32'(hit_p1), 32'd1);
    check("t1_no_miss", 32'({miss_p1, miss_p2, hit_p2}), 32'd0);
    check("t1_scores", 32'({score_p1, score_p2}), 32'h00);
    tick();
    check("t1_hit_one_cycle", 32'(hit_p1), 32'd0);
    active_obj = 1'b0; active_paddle_p1 = 1'b0;

    // T2 miss by P2, ball lingers 5 cycles
    pulse_fsync();
    vpos = 12'sd20; active_obj = 1'b1; active_paddle_p2 = 1'b0;
    tick();
    check("t2_no_hit", 32'({hit_p1, hit_p2}), 32'd0);
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      vpos = 12'(21 + i);
      tick();
      acc |= {14'd0, miss_p1, miss_p2};
    end
    check("t2_no_early_miss", 32'(acc), 32'd0);
    active_obj = 1'b0;
    tick();
    check("t2_miss_p2", 32'({miss_p1, miss_p2}), 32'b01);
    check("t2_score_p1", 32'(score_p1), 32'd1);
    check("t2_score_p2", 32'(score_p2), 32'd0);
    check("t2_game_over", 32'(game_over), 32'd1);
    tick();
    check("t2_miss_one_cycle", 32'(miss_p2), 32'd0);

    // T3 pause: 128 fsyncs hold, the 129th restarts
    fsyncs(128);
    check("t3_still_over", 32'({game_over, round_restart}), 32'b10);
    pulse_fsync();
    check("t3_restart", 32'({game_over, round_restart}), 32'b01);
    tick();
    check("t3_restart_one_cycle", 32'(round_restart), 32'd0);
    check("t3_scores_hold", 32'({score_p1, score_p2}), 32'h10);

    // T6 row event together with fsync in SCAN
    pulse_fsync();
    vpos = 12'sd700; active_obj = 1'b1; active_paddle_p1 = 1'b1; fsync = 1'b1;
    tick();
    fsync = 1'b0;
    check("t6_row_wins", 32'(hit_p1), 32'd1);
    tick();
    check("t6_back_to_wait", 32'(hit_p1), 32'd0);
    active_obj = 1'b0; active_paddle_p1 = 1'b0;

    // T5 reset mid-PAUSE (pause counter at 40)
    miss_p1_round();
    check("t5_miss_p1", 32'({miss_p1, score_p2}), 32'h11);
    fsyncs(40);
    check("t5_in_pause", 32'(game_over), 32'd1);
    rst = 1'b1;
    tick();
    check("t5_reset_outputs", 32'(all_out()), 32'h0);
    rst = 1'b0;
    vpos = 12'sd700; active_obj = 1'b1;
    tick();
    check("t5_state_wait", 32'(all_out()), 32'h0);
    active_obj = 1'b0;

    // T4 nine consecutive P1 misses end the match
    for (int i = 1; i <= 9; i++) begin
      miss_p1_round();
      check($sformatf("t4_miss_%0d", i), 32'({miss_p1, miss_p2}), 32'b10);
      check($sformatf("t4_score_p2_%0d", i), 32'(score_p2), 32'(i));
      if (i < 9) begin
        check($sformatf("t4_not_over_%0d", i), 32'(match_over), 32'd0);
        fsyncs(128);
        pulse_fsync();
        check($sformatf("t4_restart_%0d", i), 32'(round_restart), 32'd1);
        tick();
      end
    end
    check("t4_match_over", 32'({match_over, winner, game_over}), 32'b111);
    check("t4_score_p1", 32'(score_p1), 32'd0);

    // Activity after match end must not pulse or score.
    acc = '0;
    for (int i = 0; i < 6; i++) begin
      fsync            = (i % 2 == 0);
      vpos             = (i < 3) ? 12'sd700 : 12'sd20;
      active_obj       = (i % 3 != 2);
      active_paddle_p1 = (i == 0);
      active_paddle_p2 = (i == 3);
      tick();
      acc |= {12'd0, hit_p1, hit_p2, miss_p1, miss_p2};
    end
    fsync = 1'b0; active_obj = 1'b0; active_paddle_p1 = 1'b0; active_paddle_p2 = 1'b0;
    tick();
    check("t4_no_pulses", 32'(acc), 32'd0);
    check("t4_scores_hold", 32'({score_p1, score_p2}), 32'h09);
    check("t4_still_ended", 32'({match_over, winner, game_over, round_restart}), 32'b1110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
